// File: rtl/gauss_pkg.sv
// Shared types and widths for the Gaussian sampler initiator.
package gauss_pkg;

  localparam int WORD_W      = 64;
  localparam int SAMP_W      = 32;
  localparam int TIMEOUT_DEF = 2000;
  localparam int GAP_DEF     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SEND_A = 3'd2,
    GAP1   = 3'd3,
    SEND_B = 3'd4,
    WAIT   = 3'd5,
    OUT    = 3'd6,
    COOL   = 3'd7
  } gauss_state_e;

endpackage

// File: rtl/gauss_sample_driver_if.sv
// PRNG word stream, sampler (r1/r2 -> val) and downstream sample stream.
interface gauss_sample_driver_if;
  import gauss_pkg::*;

  logic                     rnd_valid;
  logic [WORD_W-1:0]        rnd_data;
  logic                     rnd_ready;
  logic                     r1_valid;
  logic                     r2_valid;
  logic [WORD_W-1:0]        r1;
  logic [WORD_W-1:0]        r2;
  logic                     val_valid;
  logic signed [SAMP_W-1:0] val;
  logic                     samp_valid;
  logic signed [SAMP_W-1:0] samp_data;
  logic                     samp_ready;

  modport master (
    input  rnd_valid, rnd_data, val_valid, val, samp_ready,
    output rnd_ready, r1_valid, r2_valid, r1, r2, samp_valid, samp_data
  );

  modport slave (
    output rnd_valid, rnd_data, val_valid, val, samp_ready,
    input  rnd_ready, r1_valid, r2_valid, r1, r2, samp_valid, samp_data
  );

endinterface

// File: rtl/gauss_word_buf.sv
// Four-word PRNG buffer: arm restarts a fill, rnd_ready is registered and drops with the 4th transfer.
module gauss_word_buf
  import gauss_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    rnd_valid,
  input  logic [WORD_W-1:0]       rnd_data,
  output logic                    rnd_ready,
  output logic                    full,
  output logic [3:0][WORD_W-1:0]  w
);

  logic [1:0] fill_cnt;
  logic       xfer;

  assign xfer = rnd_valid && rnd_ready;
  // full flags the cycle in which the last word lands, so the FSM can leave FILL on that edge
  assign full = xfer && (fill_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_ready <= 1'b0;
      fill_cnt  <= 2'd0;
    end else if (arm) begin
      rnd_ready <= 1'b1;
      fill_cnt  <= 2'd0;
    end else if (xfer) begin
      fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd3)
        rnd_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)
      w[fill_cnt] <= rnd_data;
  end

endmodule

// File: rtl/gauss_sample_driver.sv
// Initiator for the mkgauss sampler: fetches 4 PRNG words per sample, issues two r1/r2 pairs, forwards val.
// Optional latency statistics ports are enabled by defining GAUSS_DRV_STATS_EN.
module gauss_sample_driver
  import gauss_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_samples,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  gauss_sample_driver_if.master bus
`ifdef GAUSS_DRV_STATS_EN
  ,
  output logic [31:0]           stat_lat_total,
  output logic [15:0]           stat_lat_max
`endif
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_FILL   = FILL;
  localparam logic [2:0] S_SEND_A = SEND_A;
  localparam logic [2:0] S_GAP1   = GAP1;
  localparam logic [2:0] S_SEND_B = SEND_B;
  localparam logic [2:0] S_WAIT   = WAIT;
  localparam logic [2:0] S_OUT    = OUT;
  localparam logic [2:0] S_COOL   = COOL;

  logic [2:0]                state;
  logic [15:0]               n_lat;
  logic [15:0]               samp_cnt;
  logic [15:0]               tcnt;
  logic [15:0]               gap_cnt;
  logic                      samp_vld;
  logic signed [SAMP_W-1:0]  samp_q;
  logic                      rnd_rdy;
  logic                      buf_full;
  logic [3:0][WORD_W-1:0]    w;
  logic                      start_acc;
  logic                      cool_exit;
  logic                      batch_end;
  logic                      wait_expired;
  logic                      arm;

  gauss_word_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .rnd_valid (bus.rnd_valid),
    .rnd_data  (bus.rnd_data),
    .rnd_ready (rnd_rdy),
    .full      (buf_full),
    .w         (w)
  );

  assign bus.rnd_ready  = rnd_rdy;
  assign bus.samp_valid = samp_vld;
  assign bus.samp_data  = samp_q;

  always_comb begin
    start_acc    = (state == S_IDLE) && start;
    cool_exit    = (state == S_COOL) && !bus.val_valid && (gap_cnt == 16'(GAP_CYCLES));
    batch_end    = cool_exit && (samp_cnt == n_lat);
    wait_expired = (state == S_WAIT) && !bus.val_valid && (tcnt == 16'(TIMEOUT - 1));
    arm          = (start_acc && (num_samples != 16'd0)) || (cool_exit && !batch_end);
  end

  // r1/r2 are decoded from state so they read zero whenever their valids are low
  always_comb begin
    bus.r1_valid = 1'b0;
    bus.r2_valid = 1'b0;
    bus.r1       = '0;
    bus.r2       = '0;
    if (state == S_SEND_A) begin
      bus.r1_valid = 1'b1;
      bus.r2_valid = 1'b1;
      bus.r1       = w[0];
      bus.r2       = w[1];
    end else if (state == S_SEND_B) begin
      bus.r1_valid = 1'b1;
      bus.r2_valid = 1'b1;
      bus.r1       = w[2];
      bus.r2       = w[3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      samp_vld    <= 1'b0;
      samp_q      <= '0;
      n_lat       <= '0;
      samp_cnt    <= '0;
      tcnt        <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            n_lat       <= num_samples;
            err_timeout <= 1'b0;
            samp_cnt    <= '0;
            if (num_samples == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_FILL;
            end
          end
        end
        S_FILL:   if (buf_full) state <= S_SEND_A;
        S_SEND_A: state <= S_GAP1;
        S_GAP1:   state <= S_SEND_B;
        S_SEND_B: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.val_valid) begin
            samp_q   <= bus.val;
            samp_vld <= 1'b1;
            state    <= S_OUT;
          end else if (wait_expired) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_OUT: begin
          if (bus.samp_ready) begin
            samp_vld <= 1'b0;
            samp_cnt <= samp_cnt + 16'd1;
            gap_cnt  <= '0;
            state    <= S_COOL;
          end
        end
        S_COOL: begin
          // a sampler still holding val_valid restarts the idle gap
          if (bus.val_valid) begin
            gap_cnt <= '0;
          end else if (cool_exit) begin
            if (batch_end) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_FILL;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GAUSS_DRV_STATS_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic        leave_wait;
  logic [15:0] wait_len;

  assign leave_wait = (state == S_WAIT) && (bus.val_valid || wait_expired);
  assign wait_len   = tcnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lat_total <= '0;
      stat_lat_max   <= '0;
    end else if (start_acc) begin
      stat_lat_total <= '0;
      stat_lat_max   <= '0;
    end else if (leave_wait) begin
      stat_lat_total <= sat_add32(stat_lat_total, {16'd0, wait_len});
      if (wait_len > stat_lat_max)
        stat_lat_max <= wait_len;
    end
  end
`endif

endmodule

// File: tb/tb_gauss_sample_driver.sv
// Directed bench for gauss_sample_driver with word and sample scoreboards.
module tb_gauss_sample_driver;
  import gauss_pkg::*;

  localparam int TB_TIMEOUT = 2000;
  localparam int TB_GAP     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        busy, done, err_timeout;

  gauss_sample_driver_if bus ();

  gauss_sample_driver #(.TIMEOUT(TB_TIMEOUT), .GAP_CYCLES(TB_GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int send_cnt = 0, sendA_cyc = 0, sendB_cyc = 0;
  int samp_hs = 0, hs_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int rdy_rises = 0, rdy_rise_cyc = 0;
  bit rdy_prev = 1'b0;
  int words_taken = 0;
  logic [63:0] word_base = '0;
  bit prng_on = 1'b0, prng_gaps = 1'b0;
  logic [63:0] exp_words[$];
  int          exp_samp[$];
  int d0, t0, r0, s0, h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe at negedge, then drive the PRNG stream 2 time units after posedge.
  task automatic cyc();
    @(negedge clk);
    cyc_cnt++;
    if (!rst) begin
      if (bus.rnd_valid && bus.rnd_ready) begin
        exp_words.push_back(bus.rnd_data);
        words_taken++;
      end
      if (bus.r1_valid || bus.r2_valid) begin
        send_cnt++;
        if (send_cnt % 2 == 1) sendA_cyc = cyc_cnt; else sendB_cyc = cyc_cnt;
        chk("r_valid_pair", {bus.r1_valid, bus.r2_valid}, 2'b11);
        if (exp_words.size() >= 2) begin
          chk("r1_word", bus.r1, exp_words.pop_front());
          chk("r2_word", bus.r2, exp_words.pop_front());
        end else begin
          chk("r_word_avail", exp_words.size(), 2);
        end
      end else begin
        chk("r_idle_zero", bus.r1 | bus.r2, 0);
      end
      if (bus.val_valid)
        chk("r_vs_val", bus.r1_valid | bus.r2_valid, 0);
      if (bus.samp_valid) begin
        if (exp_samp.size() == 0) begin
          chk("samp_unexpected", 1, 0);
        end else if (bus.samp_ready) begin
          chk("samp_data", bus.samp_data, exp_samp.pop_front());
          samp_hs++;
          hs_cyc = cyc_cnt;
        end else begin
          chk("samp_hold", bus.samp_data, exp_samp[0]);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (bus.rnd_ready && !rdy_prev) begin
        rdy_rises++;
        rdy_rise_cyc = cyc_cnt;
      end
      rdy_prev = bus.rnd_ready;
    end
    @(posedge clk);
    #2;
    if (prng_on) begin
      bus.rnd_valid = prng_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.rnd_data  = word_base + 64'(words_taken);
    end else begin
      bus.rnd_valid = 1'b0;
    end
  endtask

  task automatic start_batch(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d_before, input string tag);
    for (int i = 0; i < 100 && done_cnt == d_before; i++) cyc();
    chk(tag, done_cnt - d_before, 1);
  endtask

  // Waits for SEND_B, answers with v (later cycles show 'other'), holds val_valid 'hold' cycles,
  // keeps samp_ready low for rdy_dly cycles, optionally pulses start during WAIT.
  task automatic do_sample(input int v, input int other, input int hold, input int rdy_dly, input bit poke);
    int target, hs_before;
    target = send_cnt + 2;
    hs_before = samp_hs;
    for (int i = 0; i < 300 && send_cnt < target; i++) cyc();
    chk("sends_seen", send_cnt - (target - 2), 2);
    chk("sendA_gap_sendB", sendB_cyc - sendA_cyc, 2);
    if (poke) begin
      start = 1'b1;
      num_samples = 16'd7;
      cyc();
      start = 1'b0;
    end
    bus.val_valid = 1'b1;
    bus.val = v;
    exp_samp.push_back(v);
    for (int i = 0; i < hold || i <= rdy_dly; i++) begin
      if (i == hold) bus.val_valid = 1'b0;
      bus.samp_ready = (i >= rdy_dly);
      cyc();
      bus.val = other;
    end
    bus.val_valid = 1'b0;
    for (int i = 0; i < 20 && samp_hs == hs_before; i++) begin
      bus.samp_ready = 1'b1;
      cyc();
    end
    chk("one_sample", samp_hs - hs_before, 1);
    bus.samp_ready = 1'b0;
  endtask

  initial begin
    bus.rnd_valid = 1'b0;
    bus.rnd_data = '0;
    bus.val_valid = 1'b0;
    bus.val = '0;
    bus.samp_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_ctrl", {busy, done, err_timeout, bus.rnd_ready, bus.r1_valid, bus.r2_valid, bus.samp_valid}, 0);
    chk("rst_r1", bus.r1, 0);
    chk("rst_r2", bus.r2, 0);
    chk("rst_samp_data", bus.samp_data, 0);
    rst = 1'b0;
    cyc();

    // reset in the middle of FILL
    word_base = 64'd100;
    words_taken = 0;
    prng_on = 1'b1;
    d0 = done_cnt;
    start_batch(16'd1);
    for (int i = 0; i < 50 && words_taken < 2; i++) cyc();
    chk("fill_two_words", words_taken, 2);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {busy, done, bus.rnd_ready, bus.r1_valid, bus.r2_valid, bus.samp_valid}, 0);
    cyc();
    chk("midrst_no_done", done, 0);
    cyc();
    exp_words.delete();
    rst = 1'b0;
    cyc();
    chk("midrst_no_done_cnt", done_cnt - d0, 0);
    t0 = words_taken;
    d0 = done_cnt;
    start_batch(16'd1);
    do_sample(9, 9, 1, 0, 1'b0);
    wait_done(d0, "refetch_done");
    chk("refetch_words", words_taken - t0, 4);

    // single sample, words 1..4, val held three cycles
    cyc();
    word_base = 64'd1;
    words_taken = 0;
    d0 = done_cnt;
    start_batch(16'd1);
    chk("busy_after_start", busy, 1);
    do_sample(-17, 77, 3, 0, 1'b0);
    wait_done(d0, "single_done");
    repeat (5) cyc();
    chk("single_done_once", done_cnt - d0, 1);
    chk("single_words_drained", exp_words.size(), 0);
    chk("single_busy_clear", busy, 0);

    // downstream backpressure, then refill only after handshake and cool-down
    word_base = 64'd500;
    words_taken = 0;
    d0 = done_cnt;
    start_batch(16'd2);
    do_sample(123, 55, 1, 6, 1'b0);
    r0 = rdy_rises;
    for (int i = 0; i < 20 && rdy_rises == r0; i++) cyc();
    chk("cool_then_fill", rdy_rise_cyc - hs_cyc, TB_GAP + 2);
    do_sample(-1, 3, 1, 0, 1'b0);
    wait_done(d0, "bp_done");

    // sampler never answers
    word_base = 64'd1000;
    words_taken = 0;
    d0 = done_cnt;
    start_batch(16'd1);
    s0 = send_cnt;
    for (int i = 0; i < 200 && send_cnt < s0 + 2; i++) cyc();
    chk("to_sends", send_cnt - s0, 2);
    for (int i = 0; i < TB_TIMEOUT + 50 && done_cnt == d0; i++) cyc();
    chk("to_done", done_cnt - d0, 1);
    chk("to_latency", done_cyc - sendB_cyc, TB_TIMEOUT + 1);
    chk("to_err", err_timeout, 1);
    chk("to_busy", busy, 0);

    // zero-length batch also clears the sticky timeout flag
    r0 = rdy_rises;
    d0 = done_cnt;
    start_batch(16'd0);
    cyc();
    chk("zero_done_next", done_cnt - d0, 1);
    chk("zero_err_cleared", err_timeout, 0);
    repeat (6) cyc();
    chk("zero_no_fill", rdy_rises - r0, 0);
    chk("zero_done_once", done_cnt - d0, 1);

    // three samples with PRNG gaps and a start pulse during WAIT
    word_base = 64'd2000;
    words_taken = 0;
    prng_gaps = 1'b1;
    d0 = done_cnt;
    h0 = samp_hs;
    start_batch(16'd3);
    do_sample(-5, 11, 2, 0, 1'b0);
    do_sample(32767, -9, 1, 2, 1'b1);
    do_sample(int'(32'h8000_0000), 0, 1, 0, 1'b0);
    wait_done(d0, "batch_done");
    repeat (5) cyc();
    chk("batch_words", words_taken, 12);
    chk("batch_done_once", done_cnt - d0, 1);
    chk("batch_samples", samp_hs - h0, 3);
    chk("batch_sb_empty", exp_samp.size() + exp_words.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
